// File: rtl/key_input_bank.sv
// Debounced key bank: per-channel 2-flop synchroniser, stability counter, level and edge pulses.
// Define KEY_REPEAT_EN to add hold-to-repeat pulses on key_press.
module key_input_bank #(
  parameter int N_KEYS          = 6,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int ACTIVE_LOW      = 0,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic              key_any
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [N_KEYS-1:0] RAW_IDLE = (ACTIVE_LOW != 0) ? {N_KEYS{1'b1}} : {N_KEYS{1'b0}};

  // Repeat timing is only meaningful with positive intervals; the guard also keeps
  // the repeat parameters referenced when the repeat feature is compiled out.
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat_params
  end

  logic [N_KEYS-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [N_KEYS-1:0] key_norm, toggle, press_edge;
  logic [CNT_W-1:0]  cnt_q [N_KEYS];
  logic [CNT_W-1:0]  cnt_d [N_KEYS];
  logic [N_KEYS-1:0] level_q, level_d, press_q, press_d, release_q, release_d;
  logic              any_q, any_d;

  always_comb begin
    sync1_d  = key_in;
    sync2_d  = sync1_q;
    key_norm = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;
    toggle   = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      cnt_d[i] = '0;
      if (key_norm[i] != level_q[i]) begin
        // Terminal count accepts the new level; the counter never wraps.
        if (cnt_q[i] == CNT_TC) toggle[i] = 1'b1;
        else                    cnt_d[i]  = cnt_q[i] + CNT_W'(1);
      end
    end
    level_d    = level_q ^ toggle;
    press_edge = toggle & ~level_q;
    release_d  = toggle & level_q;
    any_d      = |level_q;
  end

`ifdef KEY_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] REP_DLY_LD = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_PER_LD = REP_W'(REPEAT_PERIOD - 1);

  logic [REP_W-1:0]  rep_q [N_KEYS];
  logic [REP_W-1:0]  rep_d [N_KEYS];
  logic [N_KEYS-1:0] rep_fire;

  always_comb begin
    rep_fire = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      rep_d[i] = '0;
      if (press_edge[i]) begin
        rep_d[i] = REP_DLY_LD;
      end else if (level_q[i] && !toggle[i]) begin
        // Down-counter reloads with the period each time it fires.
        if (rep_q[i] == '0) begin
          rep_fire[i] = 1'b1;
          rep_d[i]    = REP_PER_LD;
        end else begin
          rep_d[i] = rep_q[i] - REP_W'(1);
        end
      end
    end
    press_d = press_edge | rep_fire;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_KEYS; i++) rep_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_KEYS; i++) rep_q[i] <= rep_d[i];
    end
  end
`else
  always_comb press_d = press_edge;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= RAW_IDLE;
      sync2_q   <= RAW_IDLE;
      for (int i = 0; i < N_KEYS; i++) cnt_q[i] <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      any_q     <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      for (int i = 0; i < N_KEYS; i++) cnt_q[i] <= cnt_d[i];
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      any_q     <= any_d;
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_any     = any_q;

endmodule

// File: doc/key_input_bank.md
KEY_INPUT_BANK -- requirements
Module: key_input_bank

Interface
REQ-001 SHALL have parameter N_KEYS, default 6, number of independent key channels (1..32).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, stable-input cycles required to accept a level change (>=2).
REQ-003 SHALL have parameter ACTIVE_LOW, default 0; 1 = a raw 0 on key_in means pressed.
REQ-004 SHALL have parameter REPEAT_DELAY, default 25000000, hold cycles before the first auto-repeat pulse (used only with KEY_REPEAT_EN).
REQ-005 SHALL have parameter REPEAT_PERIOD, default 5000000, cycles between auto-repeat pulses (used only with KEY_REPEAT_EN).
REQ-006 SHALL have port clk, input, 1, single system clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port key_in, input, N_KEYS, raw asynchronous button inputs.
REQ-009 SHALL have port key_level, output, N_KEYS, debounced level; 1 = pressed, independent of ACTIVE_LOW.
REQ-010 SHALL have port key_press, output, N_KEYS, one-cycle pulse per accepted press (and per repeat).
REQ-011 SHALL have port key_release, output, N_KEYS, one-cycle pulse per accepted release.
REQ-012 SHALL have port key_any, output, 1, registered OR of key_level.

Function
REQ-013 Each channel SHALL pass key_in through a 2-flop synchroniser, then normalise polarity per ACTIVE_LOW.
REQ-014 Each channel SHALL hold a counter of width clog2(DEBOUNCE_CYCLES); it clears when the synchronised value equals key_level and increments otherwise.
REQ-015 When the counter reaches DEBOUNCE_CYCLES-1 while still differing, key_level SHALL toggle on that edge and the counter SHALL clear.
REQ-016 A key_in change held stable SHALL appear on key_level exactly DEBOUNCE_CYCLES+2 cycles later.
REQ-017 Any input pulse or bounce shorter than DEBOUNCE_CYCLES cycles SHALL leave key_level, key_press and key_release unchanged and restart the count.
REQ-018 key_press SHALL be high for exactly the one cycle in which key_level goes 0->1; key_release likewise for 1->0; both are registered.
REQ-019 key_press and key_release of one channel SHALL never be high in the same cycle.
REQ-020 Channels SHALL be fully independent; simultaneous changes on several channels SHALL produce simultaneous pulses.
REQ-021 key_any SHALL follow the OR of key_level with one cycle of latency.
REQ-022 Counters SHALL never wrap; the terminal value is DEBOUNCE_CYCLES-1.

Reset
REQ-023 rst high SHALL asynchronously force the synchronisers to the inactive raw value, and set all counters, key_level, key_press, key_release and key_any to 0.
REQ-024 Release of rst SHALL be synchronous to clk; a key held through reset SHALL produce key_press DEBOUNCE_CYCLES+2 cycles after rst falls.
REQ-025 Reset mid-count or mid-repeat SHALL discard all progress; no pulse SHALL be emitted for the interrupted event.

Configuration
REQ-026 Macro KEY_REPEAT_EN defined: each channel SHALL have a repeat counter; after key_level has been 1 for REPEAT_DELAY cycles from its press pulse, key_press SHALL pulse again, then every REPEAT_PERIOD cycles while held.
REQ-027 With KEY_REPEAT_EN, release SHALL stop repeats immediately and clear the repeat counter; no repeat pulse in the release cycle.
REQ-028 Without KEY_REPEAT_EN, no repeat logic SHALL be synthesised, REPEAT_* are ignored, and there is exactly one key_press per accepted press.

Verification (DEBOUNCE_CYCLES=4, N_KEYS=4, ACTIVE_LOW=0, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-029 key_in[0] 0->1 held -> key_level[0]=1 and key_press[0] one-cycle pulse exactly 6 cycles later; key_any=1 one cycle after that.
REQ-030 key_in[1] high for 3 cycles, then low -> no change on any output.
REQ-031 key_in[2] bounces 1,0,1,0 every cycle, then holds 1 -> single key_press[2] 6 cycles after the final rising edge; release held -> single key_release[2].
REQ-032 key_in=4'b1111 held through rst, rst dropped -> key_press=4'b1111 simultaneously 6 cycles after rst falls.
REQ-033 rst asserted 3 cycles into a debounce count -> all outputs 0 immediately; no pulse afterwards until a fresh full count.
REQ-034 With KEY_REPEAT_EN, key_in[3] held 30 cycles -> key_press[3] at press, +10, +13, +16, ... cycles; none after key_release[3]; without macro only the first pulse.
